decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and immediate width; legal values 32, 64.
REQ-002 Parameter DEPTH, default 2, output queue entries; power of two, at least 2.
REQ-003 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous queue clear.
REQ-007 in_valid  input  1  upstream instruction valid.
REQ-008 in_ready  output  1  stage can accept an instruction.
REQ-009 in_instr  input  32  raw instruction word.
REQ-010 in_pc  input  XLEN  instruction address.
REQ-011 out_valid  output  1  queue head valid.
REQ-012 out_ready  input  1  downstream accepts the head.
REQ-013 out_opcode  output  7, out_rd  output  5, out_rs1  output  5, out_rs2  output  5: decoded fields.
REQ-014 out_funct3  output  3, out_funct7  output  7: decoded fields.
REQ-015 out_imm  output  XLEN  sign-extended immediate.
REQ-016 out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-017 out_illegal  output  1, out_pc  output  XLEN: illegal flag and head address.
REQ-018 illegal_count  output  CNT_W  count of accepted illegal instructions.

Function
REQ-019 Accept when in_valid && in_ready && !flush; the decoded word is written into the queue tail at that edge.
REQ-020 in_ready SHALL be 1 exactly when occupancy < DEPTH; it does not depend on out_ready, so there is no full pass-through.
REQ-021 out_valid SHALL be 1 exactly when occupancy > 0; latency from accept to out_valid is 1 cycle.
REQ-022 Pop when out_valid && out_ready && !flush; simultaneous push and pop leave occupancy unchanged.
REQ-023 Head outputs SHALL hold stable while out_valid && !out_ready.
REQ-024 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy is a log2(DEPTH)+1-bit counter.
REQ-025 Opcode to format: 0000011, 0010011, 1100111, 1110011 map to I; 0110011 to R; 0100011 to S; 1100011 to B; 0110111, 0010111 to U; 1101111 to J.
REQ-026 Any other opcode, or in_instr[1:0] != 2'b11, is illegal: fmt=7, illegal=1, opcode passed through, all other fields 0.
REQ-027 Fields not defined by the format SHALL be 0: rd for S/B; rs1 for U/J; rs2 for I/U/J; funct3 for U/J; funct7 for all but R.
REQ-028 Immediates (R: 0) SHALL follow these layouts:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All sign-extended from bit 31 of the instruction to XLEN.
REQ-029 illegal_count SHALL increment by 1 on each accepted illegal instruction and saturate at all-ones.
REQ-030 flush SHALL set both pointers and occupancy to 0 at the edge; no push or pop occurs on that cycle; illegal_count is unaffected.

Reset
REQ-031 While rst_n=0, pointers, occupancy, and illegal_count SHALL be 0 immediately, independent of clk.
REQ-032 During reset, out_valid=0 and in_ready=0; queue storage need not be cleared.
REQ-033 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-034 Reset mid-operation discards all queued entries; no entry appears after release.

Verification
REQ-035 Accept 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, rs2=0, funct3=0, imm=5.
REQ-036 Accept 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, rd=0, imm=0xFFFFFFFC (XLEN=32); with XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
REQ-037 Accept 0x123452B7 (lui x5,0x12345) -> fmt=4, rd=5, rs1=0, imm=0x12345000.
REQ-038 DEPTH=2, out_ready=0: push 2 words -> in_ready=0, third held upstream. Then out_ready=1 -> heads pop in order, in_ready=1 one cycle after the first pop.
REQ-039 Accept 0x00000000 -> illegal=1, fmt=7, illegal_count 0->1. Then flush with 2 entries queued -> out_valid=0 next cycle, illegal_count still 1.
REQ-040 rst_n pulsed low mid-cycle with 2 entries queued -> out_valid=0 and illegal_count=0 without a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// RV32/64 base-ISA decode stage: decodes each accepted instruction word into
// its fields and buffers the results in a small FIFO with ready/valid flow control.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    entry_t      dec;
    entry_t      head;
    logic [31:0] imm32;
    logic        push;
    logic        pop;

    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.opcode = in_instr[6:0];
        dec.pc     = in_pc;
        dec.fmt    = FMT_ILL;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:0])
                7'b0000011, 7'b0010011,
                7'b1100111, 7'b1110011: dec.fmt = FMT_I;
                7'b0110011:             dec.fmt = FMT_R;
                7'b0100011:             dec.fmt = FMT_S;
                7'b1100011:             dec.fmt = FMT_B;
                7'b0110111, 7'b0010111: dec.fmt = FMT_U;
                7'b1101111:             dec.fmt = FMT_J;
                default:                dec.fmt = FMT_ILL;
            endcase
        end
        dec.illegal = (dec.fmt == FMT_ILL);
        // Only the fields a format defines are copied; the rest stay zero.
        case (dec.fmt)
            FMT_R: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                dec.funct7 = in_instr[31:25];
            end
            FMT_I: begin
                dec.rd     = in_instr[11:7];
                dec.rs1    = in_instr[19:15];
                dec.funct3 = in_instr[14:12];
                imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            FMT_S: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            FMT_B: begin
                dec.rs1    = in_instr[19:15];
                dec.rs2    = in_instr[24:20];
                dec.funct3 = in_instr[14:12];
                imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end
            FMT_U: begin
                dec.rd     = in_instr[11:7];
                imm32      = {in_instr[31:12], 12'b0};
            end
            FMT_J: begin
                dec.rd     = in_instr[11:7];
                imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            end
            default: ;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_ready  = rst_n && (occ_q < (PTR_W+1)'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            occ_d = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
        if (push && dec.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Storage is qualified by occupancy, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head          = mem_q[rd_ptr_q];
    assign out_opcode    = head.opcode;
    assign out_rd        = head.rd;
    assign out_rs1       = head.rs1;
    assign out_rs2       = head.rs2;
    assign out_funct3    = head.funct3;
    assign out_funct7    = head.funct7;
    assign out_imm       = head.imm;
    assign out_fmt       = head.fmt;
    assign out_illegal   = head.illegal;
    assign out_pc        = head.pc;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the decode FIFO.
module tb_decode_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [CNT_W-1:0] illegal_count;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   model_cnt;
    bit   in_rst;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the format rules using signed arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   sw;
        int   fmt;
        bit   has_rd, has_rs1, has_rs2, has_f3;
        e = '0;
        sw = int'(w);
        e.opcode = w[6:0];
        e.pc = pc;
        fmt = 7;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h03, 7'h13, 7'h67, 7'h73: fmt = 1;
                7'h33: fmt = 0;
                7'h23: fmt = 2;
                7'h63: fmt = 3;
                7'h37, 7'h17: fmt = 4;
                7'h6f: fmt = 5;
                default: fmt = 7;
            endcase
        end
        e.fmt = 3'(fmt);
        e.ill = (fmt == 7);
        has_rd  = (fmt == 0) || (fmt == 1) || (fmt == 4) || (fmt == 5);
        has_rs1 = (fmt <= 3);
        has_rs2 = (fmt == 0) || (fmt == 2) || (fmt == 3);
        has_f3  = (fmt <= 3);
        if (has_rd)  e.rd  = w[11:7];
        if (has_rs1) e.rs1 = w[19:15];
        if (has_rs2) e.rs2 = w[24:20];
        if (has_f3)  e.f3  = w[14:12];
        if (fmt == 0) e.f7 = w[31:25];
        case (fmt)
            1: e.imm = 32'(sw >>> 20);
            2: e.imm = 32'(((sw >>> 25) * 32) + int'(w[11:7]));
            3: e.imm = 32'(((sw >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            4: e.imm = w & 32'hFFFF_F000;
            5: e.imm = 32'(((sw >>> 31) * 1048576) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            default: e.imm = 32'h0;
        endcase
        return e;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({where, ".in_ready"}, 64'(in_ready), 64'(!in_rst && q.size() < DEPTH));
        chk({where, ".illegal_count"}, 64'(illegal_count), 64'(model_cnt));
        if (q.size() > 0) begin
            chk({where, ".opcode"}, 64'(out_opcode), 64'(q[0].opcode));
            chk({where, ".rd"}, 64'(out_rd), 64'(q[0].rd));
            chk({where, ".rs1"}, 64'(out_rs1), 64'(q[0].rs1));
            chk({where, ".rs2"}, 64'(out_rs2), 64'(q[0].rs2));
            chk({where, ".funct3"}, 64'(out_funct3), 64'(q[0].f3));
            chk({where, ".funct7"}, 64'(out_funct7), 64'(q[0].f7));
            chk({where, ".imm"}, 64'(out_imm), 64'(q[0].imm));
            chk({where, ".fmt"}, 64'(out_fmt), 64'(q[0].fmt));
            chk({where, ".illegal"}, 64'(out_illegal), 64'(q[0].ill));
            chk({where, ".pc"}, 64'(out_pc), 64'(q[0].pc));
        end
    endtask

    task automatic cycle(input string where, input logic v, input logic [31:0] w,
                         input logic [31:0] pc, input logic ordy, input logic fl);
        bit   acc, pp;
        exp_t e;
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        e   = ref_decode(w, pc);
        acc = v && !in_rst && (q.size() < DEPTH) && !fl;
        pp  = (q.size() > 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (e.ill && model_cnt < (1 << CNT_W) - 1) model_cnt++;
            end
        end
        check_all(where);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        if (sel < 10) w[6:0] = ops[sel];
        else if (sel == 11) w[1:0] = 2'($urandom_range(0, 2));
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        model_cnt = 0;
        #12;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd0);
        chk("reset.illegal_count", 64'(illegal_count), 64'd0);
        #10;
        rst_n = 1'b1; in_rst = 1'b0;
        #1;
        chk("release.in_ready", 64'(in_ready), 64'd1);

        // addi x1,x0,5
        cycle("addi", 1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        chk("addi.fmt", 64'(out_fmt), 64'd1);
        chk("addi.rd", 64'(out_rd), 64'd1);
        chk("addi.imm", 64'(out_imm), 64'd5);
        cycle("drain0", 1'b0, '0, '0, 1'b1, 1'b0);

        // beq x0,x0,-4
        cycle("beq", 1'b1, 32'hFE00_0EE3, 32'h104, 1'b1, 1'b0);
        chk("beq.fmt", 64'(out_fmt), 64'd3);
        chk("beq.rd", 64'(out_rd), 64'd0);
        chk("beq.imm", 64'(out_imm), 64'hFFFF_FFFC);
        cycle("drain1", 1'b0, '0, '0, 1'b1, 1'b0);

        // lui x5,0x12345
        cycle("lui", 1'b1, 32'h1234_52B7, 32'h108, 1'b1, 1'b0);
        chk("lui.fmt", 64'(out_fmt), 64'd4);
        chk("lui.rd", 64'(out_rd), 64'd5);
        chk("lui.rs1", 64'(out_rs1), 64'd0);
        chk("lui.imm", 64'(out_imm), 64'h1234_5000);
        cycle("drain2", 1'b0, '0, '0, 1'b1, 1'b0);

        // Fill to DEPTH with downstream stalled; a third word is held off.
        cycle("fill1", 1'b1, 32'h0030_0113, 32'h200, 1'b0, 1'b0);
        cycle("fill2", 1'b1, 32'h0020_81B3, 32'h204, 1'b0, 1'b0);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        cycle("held", 1'b1, 32'h0000_006F, 32'h208, 1'b0, 1'b0);
        chk("held.pc", 64'(out_pc), 64'h200);
        cycle("pop1", 1'b0, '0, '0, 1'b1, 1'b0);
        chk("pop1.in_ready", 64'(in_ready), 64'd1);
        chk("pop1.pc", 64'(out_pc), 64'h204);
        cycle("pop2", 1'b0, '0, '0, 1'b1, 1'b0);

        // Illegal word, then flush with two entries queued.
        cycle("ill", 1'b1, 32'h0000_0000, 32'h300, 1'b0, 1'b0);
        chk("ill.illegal", 64'(out_illegal), 64'd1);
        chk("ill.fmt", 64'(out_fmt), 64'd7);
        chk("ill.count", 64'(illegal_count), 64'd1);
        cycle("ill2", 1'b1, 32'h0000_0013, 32'h304, 1'b0, 1'b0);
        cycle("flush", 1'b1, 32'h0000_0000, 32'h308, 1'b1, 1'b1);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.count", 64'(illegal_count), 64'd1);

        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), rand_instr(),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            cycle("sat", 1'b1, 32'h0000_0001, 32'h400, 1'b1, 1'b0);
        end
        chk("sat.count", 64'(illegal_count), 64'hF);

        // Asynchronous reset with two entries queued.
        cycle("pre_rst1", 1'b1, 32'h0010_0093, 32'h500, 1'b0, 1'b0);
        cycle("pre_rst2", 1'b1, 32'h0010_0093, 32'h504, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0; in_rst = 1'b1;
        q.delete(); model_cnt = 0;
        #1;
        chk("async_rst.out_valid", 64'(out_valid), 64'd0);
        chk("async_rst.count", 64'(illegal_count), 64'd0);
        chk("async_rst.in_ready", 64'(in_ready), 64'd0);
        #1;
        rst_n = 1'b1; in_rst = 1'b0;
        cycle("post_rst", 1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle("rand2", ($urandom_range(0, 1) != 0), rand_instr(),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
